// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the ALU arbiter and its ALU.
//   alu_op_e    : 2-bit ALU control encoding (add/sub/and/xor)
//   rsp_state_e : occupancy of the one-entry response buffer
//   CC_*_RST    : condition-code values after reset (ZF set, SF/OF clear)
//   WIDTH_DEFAULT : default datapath width
package y86_pkg;

  localparam int WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  localparam logic CC_ZF_RST = 1'b1;
  localparam logic CC_SF_RST = 1'b0;
  localparam logic CC_OF_RST = 1'b0;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational Y86-64 ALU.
// Ports:
//   op       in  2      alu control (alu_op_e encoding)
//   a, b     in  WIDTH  signed operands
//   result   out WIDTH  a op b, wrapping mod 2^WIDTH
//   overflow out 1      signed overflow for add/sub, 0 for and/xor
module alu_arbiter_alu
  import y86_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op_e'(op))
      ALU_ADD: begin
        result   = a + b;
        // Same-sign operands producing a result of the other sign.
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = a - b;
        // Differing-sign operands where the result flips away from a's sign.
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between r0 (execute-stage OPq) and
// r1 (address / stack-pointer adjust), with a one-entry registered response
// buffer and the Y86-64 condition-code register (updated only by r0).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   r0_valid/ready/op/a/b      r0 request handshake and payload
//   r0_set_cc                  update ZF/SF/OF when the r0 op is accepted
//   r1_valid/ready/op/a/b      r1 request handshake and payload
//   rsp_valid/ready            response buffer handshake
//   rsp_id/value/overflow      issuing requester, result, alu overflow
//   cc_zf, cc_sf, cc_of        condition codes
module alu_arbiter
  import y86_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter bit RR_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [1:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_set_cc,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [1:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_value,
  output logic             rsp_overflow,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  rsp_state_e       state_q, state_d;
  logic             last_q, last_d;  // id of the most recently accepted requester
  logic             id_q, id_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             ovf_q, ovf_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;

  logic             can_accept;
  logic             grant0, grant1;
  logic             accept;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_overflow;

  // Grant and ready depend only on valids and current state.
  always_comb begin
    can_accept = (state_q == ST_EMPTY) || rsp_ready;
    // On contention, r1 wins only if r0 was granted last.
    grant1     = r1_valid && (!r0_valid || !last_q);
    grant0     = r0_valid && !grant1;
    // Nothing is accepted while reset is asserted.
    r0_ready   = can_accept && grant0 && !reset;
    r1_ready   = can_accept && grant1 && !reset;
    accept     = r0_ready || r1_ready;
    alu_op     = grant1 ? r1_op : r0_op;
    alu_a      = grant1 ? r1_a  : r0_a;
    alu_b      = grant1 ? r1_b  : r0_b;
  end

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .op       (alu_op),
    .a        (alu_a),
    .b        (alu_b),
    .result   (alu_result),
    .overflow (alu_overflow)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    if (accept) begin
      // Covers both EMPTY->FULL and the no-bubble reload while FULL.
      state_d = ST_FULL;
      last_d  = grant1;
      id_d    = grant1;
      value_d = alu_result;
      ovf_d   = alu_overflow;
      if (r0_ready && r0_set_cc) begin
        zf_d = (alu_result == '0);
        sf_d = alu_result[WIDTH-1];
        of_d = alu_overflow;
      end
    end else if (state_q == ST_FULL && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      last_q  <= ~RR_FIRST;  // so RR_FIRST wins the next contention
      id_q    <= 1'b0;
      value_q <= '0;
      ovf_q   <= 1'b0;
      zf_q    <= CC_ZF_RST;
      sf_q    <= CC_SF_RST;
      of_q    <= CC_OF_RST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
    end
  end

  assign rsp_valid    = (state_q == ST_FULL);
  assign rsp_id       = id_q;
  assign rsp_value    = value_q;
  assign rsp_overflow = ovf_q;
  assign cc_zf        = zf_q;
  assign cc_sf        = sf_q;
  assign cc_of        = of_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: hand-computed expected values for each
// transaction; one line printed per transaction.
module tb_alu_arbiter;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         r0_valid, r0_ready, r0_set_cc;
  logic [1:0]   r0_op;
  logic [W-1:0] r0_a, r0_b;
  logic         r1_valid, r1_ready;
  logic [1:0]   r1_op;
  logic [W-1:0] r1_a, r1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_overflow;
  logic [W-1:0] rsp_value;
  logic         cc_zf, cc_sf, cc_of;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .RR_FIRST(1'b0)) dut (
    .clk          (clk),
    .reset        (reset),
    .r0_valid     (r0_valid),
    .r0_ready     (r0_ready),
    .r0_op        (r0_op),
    .r0_a         (r0_a),
    .r0_b         (r0_b),
    .r0_set_cc    (r0_set_cc),
    .r1_valid     (r1_valid),
    .r1_ready     (r1_ready),
    .r1_op        (r1_op),
    .r1_a         (r1_a),
    .r1_b         (r1_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_value    (rsp_value),
    .rsp_overflow (rsp_overflow),
    .cc_zf        (cc_zf),
    .cc_sf        (cc_sf),
    .cc_of        (cc_of)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational readys settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic exp_id, input logic [W-1:0] exp_val,
                           input logic exp_ovf);
    check_eq({tag, "_valid"}, W'(rsp_valid), W'(1'b1));
    check_eq({tag, "_id"}, W'(rsp_id), W'(exp_id));
    check_eq({tag, "_value"}, rsp_value, exp_val);
    check_eq({tag, "_ovf"}, W'(rsp_overflow), W'(exp_ovf));
    $display("txn %s: id=%0d value=0x%0h ovf=%0d", tag, rsp_id, rsp_value, rsp_overflow);
  endtask

  task automatic check_cc(input string tag, input logic zf, input logic sf, input logic of_v);
    check_eq({tag, "_zf"}, W'(cc_zf), W'(zf));
    check_eq({tag, "_sf"}, W'(cc_sf), W'(sf));
    check_eq({tag, "_of"}, W'(cc_of), W'(of_v));
  endtask

  task automatic drive_r0(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic set_cc);
    r0_valid = v; r0_op = op; r0_a = a; r0_b = b; r0_set_cc = set_cc;
  endtask

  task automatic drive_r1(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    r1_valid = v; r1_op = op; r1_a = a; r1_b = b;
  endtask

  initial begin
    logic exp_id;
    reset = 1'b1;
    rsp_ready = 1'b0;
    drive_r0(1'b0, 2'b00, '0, '0, 1'b0);
    drive_r1(1'b0, 2'b00, '0, '0);
    tick();
    tick();

    // Reset state
    check_eq("rst_rsp_valid", W'(rsp_valid), W'(1'b0));
    check_eq("rst_rsp_id", W'(rsp_id), W'(1'b0));
    check_eq("rst_rsp_value", rsp_value, '0);
    check_eq("rst_rsp_ovf", W'(rsp_overflow), W'(1'b0));
    check_cc("rst", 1'b1, 1'b0, 1'b0);
    $display("txn reset: rsp_valid=%0d cc=%0d%0d%0d", rsp_valid, cc_zf, cc_sf, cc_of);
    reset = 1'b0;

    // 1: r0 add max + 1 with CC update -> signed overflow
    rsp_ready = 1'b1;
    drive_r0(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    settle();
    check_eq("t1_r0_ready", W'(r0_ready), W'(1'b1));
    tick();
    drive_r0(1'b0, 2'b00, '0, '0, 1'b0);
    check_rsp("t1_add", 1'b0, 64'h8000_0000_0000_0000, 1'b1);
    check_cc("t1", 1'b0, 1'b1, 1'b1);

    // 2: r1 sub 5 - 5 -> 0, CCs untouched
    drive_r1(1'b1, 2'b01, 64'd5, 64'd5);
    settle();
    check_eq("t2_r1_ready", W'(r1_ready), W'(1'b1));
    tick();
    drive_r1(1'b0, 2'b00, '0, '0);
    check_rsp("t2_sub", 1'b1, 64'd0, 1'b0);
    check_cc("t2", 1'b0, 1'b1, 1'b1);
    tick();
    check_eq("t2_drain", W'(rsp_valid), W'(1'b0));

    // 3: contention, r1 was last granted so r0 goes first
    drive_r0(1'b1, 2'b00, 64'd1, 64'd2, 1'b0);
    drive_r1(1'b1, 2'b00, 64'd10, 64'd20);
    exp_id = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("t3_r0_ready", W'(r0_ready), W'(!exp_id));
      check_eq("t3_r1_ready", W'(r1_ready), W'(exp_id));
      tick();
      check_rsp("t3_rr", exp_id, exp_id ? 64'd30 : 64'd3, 1'b0);
      exp_id = !exp_id;
    end
    drive_r1(1'b0, 2'b00, '0, '0);

    // 4: backpressure holds response; r0 accepted the cycle rsp_ready returns
    rsp_ready = 1'b0;
    drive_r0(1'b1, 2'b00, 64'd4, 64'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("t4_r0_ready_low", W'(r0_ready), W'(1'b0));
      tick();
      check_rsp("t4_hold", 1'b1, 64'd30, 1'b0);
    end
    rsp_ready = 1'b1;
    settle();
    check_eq("t4_r0_ready_back", W'(r0_ready), W'(1'b1));
    tick();
    check_rsp("t4_reload", 1'b0, 64'd8, 1'b0);

    // 5: logic ops with CC update
    drive_r0(1'b1, 2'b10, 64'hF0F0, 64'h0FF0, 1'b1);
    tick();
    check_rsp("t5_and", 1'b0, 64'h00F0, 1'b0);
    check_cc("t5_and", 1'b0, 1'b0, 1'b0);
    drive_r0(1'b1, 2'b11, 64'hAA, 64'hAA, 1'b1);
    tick();
    check_rsp("t5_xor", 1'b0, 64'h0, 1'b0);
    check_cc("t5_xor", 1'b1, 1'b0, 1'b0);

    // r1 sub overflow: min - 1 wraps to max
    drive_r0(1'b0, 2'b00, '0, '0, 1'b0);
    drive_r1(1'b1, 2'b01, 64'h8000_0000_0000_0000, 64'h1);
    tick();
    drive_r1(1'b0, 2'b00, '0, '0);
    check_rsp("t5_subovf", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    check_cc("t5_subovf", 1'b1, 1'b0, 1'b0);

    // Set CCs away from reset values before the reset test
    drive_r0(1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    tick();
    check_cc("t6_pre", 1'b0, 1'b1, 1'b0);

    // 6: reset with a full buffer and a pending r0 request
    rsp_ready = 1'b0;
    reset = 1'b1;
    settle();
    check_eq("t6_no_accept_in_reset", W'(r0_ready), W'(1'b0));
    tick();
    check_eq("t6_rsp_valid", W'(rsp_valid), W'(1'b0));
    check_cc("t6", 1'b1, 1'b0, 1'b0);
    $display("txn reset_mid: rsp_valid=%0d cc=%0d%0d%0d", rsp_valid, cc_zf, cc_sf, cc_of);
    reset = 1'b0;
    rsp_ready = 1'b1;
    drive_r0(1'b1, 2'b00, 64'd7, 64'd1, 1'b0);
    drive_r1(1'b1, 2'b00, 64'd100, 64'd1);
    settle();
    check_eq("t6_first_r0_ready", W'(r0_ready), W'(1'b1));
    check_eq("t6_first_r1_ready", W'(r1_ready), W'(1'b0));
    tick();
    check_rsp("t6_first", 1'b0, 64'd8, 1'b0);
    drive_r0(1'b0, 2'b00, '0, '0, 1'b0);
    drive_r1(1'b0, 2'b00, '0, '0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
